// File: rtl/ahb_lite_master_port.sv
// rtl/ahb_lite_master_port.sv - single-outstanding AHB-Lite initiator driven by a cmd/rsp handshake
module ahb_lite_master_port #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ERR2,
    S_RESP
  } state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  state_t      state, state_d;
  logic [1:0]  htrans_d;
  logic [31:0] haddr_d;
  logic [2:0]  hsize_d;
  logic        hwrite_d;
  logic [31:0] hwdata_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_d;
  logic [31:0] rsp_rdata_d;
  logic [1:0]  rsp_err_d;

  logic        size_bad;
  logic        misaligned;
  logic [31:0] wdata_lanes;
  logic [31:0] rdata_shifted;
  logic [31:0] rdata_lane;

  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  assign cmd_ready = HRESETn && (state == S_IDLE);

  assign size_bad   = (cmd_size == 2'd3);
  assign misaligned = ((cmd_size == 2'd1) && cmd_addr[0]) ||
                      ((cmd_size == 2'd2) && (cmd_addr[1:0] != 2'b00));

  // Write data is replicated across every lane so any slave lane decode sees it.
  always_comb begin
    wdata_lanes = cmd_wdata;
    case (cmd_size)
      2'd0:    wdata_lanes = {4{cmd_wdata[7:0]}};
      2'd1:    wdata_lanes = {2{cmd_wdata[15:0]}};
      default: wdata_lanes = cmd_wdata;
    endcase
  end

  assign rdata_shifted = HRDATA >> {HADDR[1:0], 3'b000};

  always_comb begin
    rdata_lane = rdata_shifted;
    case (HSIZE[1:0])
      2'd0:    rdata_lane = {24'h0, rdata_shifted[7:0]};
      2'd1:    rdata_lane = {16'h0, rdata_shifted[15:0]};
      default: rdata_lane = rdata_shifted;
    endcase
  end

  always_comb begin
    state_d     = state;
    htrans_d    = HTRANS;
    haddr_d     = HADDR;
    hsize_d     = HSIZE;
    hwrite_d    = HWRITE;
    hwdata_d    = HWDATA;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (size_bad || misaligned) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'h0;
            rsp_err_d   = size_bad ? 2'd3 : 2'd2;
            state_d     = S_RESP;
          end else begin
            htrans_d = TRANS_NONSEQ;
            haddr_d  = cmd_addr;
            hsize_d  = {1'b0, cmd_size};
            hwrite_d = cmd_write;
            wdata_d  = wdata_lanes;
            state_d  = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          htrans_d = TRANS_IDLE;
          hwdata_d = HWRITE ? wdata_q : 32'h0;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (HRESP) begin
          // A single-cycle ERROR is a slave protocol violation; still report it.
          if (HREADY) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 2'd1;
            state_d     = S_RESP;
          end else begin
            state_d = S_ERR2;
          end
        end else if (HREADY) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = HWRITE ? 32'h0 : rdata_lane;
          rsp_err_d   = 2'd0;
          state_d     = S_RESP;
        end
      end
      S_ERR2: begin
        if (HREADY) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 2'd1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= S_IDLE;
      HTRANS    <= TRANS_IDLE;
      HADDR     <= 32'h0;
      HSIZE     <= 3'b000;
      HWRITE    <= 1'b0;
      HWDATA    <= 32'h0;
      wdata_q   <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 2'd0;
    end else begin
      state     <= state_d;
      HTRANS    <= htrans_d;
      HADDR     <= haddr_d;
      HSIZE     <= hsize_d;
      HWRITE    <= hwrite_d;
      HWDATA    <= hwdata_d;
      wdata_q   <= wdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master_port.sv
// tb/tb_ahb_lite_master_port.sv - directed table plus randomized commands against a reference model
module tb_ahb_lite_master_port;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_size;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK, HWRITE, HREADY, HRESP;

  always #5 HCLK = ~HCLK;

  ahb_lite_master_port #(.HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HMASTLOCK(HMASTLOCK), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    int          aw;
    int          dw;
    logic        serr;
    logic [31:0] srd;
    int          rdly;
    logic [31:0] e_rdata;
    logic [1:0]  e_err;
    int          e_lat;
    int          e_nonseq;
  } vec_t;

  int checks = 0;
  int errors = 0;

  vec_t        tbl [11];
  logic [31:0] g_rdata, m_rdata;
  logic [1:0]  g_err, m_err;
  int          g_lat, g_nonseq, g_bad, m_lat, m_nonseq;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: outcome of one command from the bus rules, cycle counts by plain arithmetic.
  task automatic model(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input int aw, input int dw, input logic serr, input logic [31:0] srd,
                       output logic [31:0] e_rdata, output logic [1:0] e_err,
                       output int e_lat, output int e_nonseq);
    longint nbytes, shifted;
    nbytes  = longint'(1) << size;
    e_rdata = 32'h0;
    if (size == 2'd3) e_err = 2'd3;
    else if ((addr % nbytes) != 0) e_err = 2'd2;
    else if (serr) e_err = 2'd1;
    else e_err = 2'd0;
    if (e_err >= 2'd2) begin
      e_lat    = 1;
      e_nonseq = 0;
    end else begin
      e_lat    = 3 + aw + dw + (serr ? 1 : 0);
      e_nonseq = 1 + aw;
      if (!wr && !serr) begin
        shifted = longint'(srd) / (longint'(1) << (8 * addr[1:0]));
        e_rdata = 32'(shifted % (longint'(1) << (8 * nbytes)));
      end
    end
  endtask

  // Drives one command, plays the slave, and returns what the DUT reported.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata, input int aw, input int dw, input logic serr,
                         input logic [31:0] srd, input int rdly,
                         output logic [31:0] got_rdata, output logic [1:0] got_err,
                         output int got_lat, output int nonseq, output int bad);
    int          ak, dk, phase;
    logic        hs, done;
    logic [31:0] exp_hw;
    case (size)
      2'd0:    exp_hw = (wdata % 256) * 32'h0101_0101;
      2'd1:    exp_hw = (wdata % 65536) * 32'h0001_0001;
      default: exp_hw = wdata;
    endcase
    ak = 0; dk = 0; phase = 0; hs = 1'b0; done = 1'b0;
    got_lat = -1; nonseq = 0; bad = 0; got_rdata = 32'h0; got_err = 2'd0;
    @(negedge HCLK);
    check("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_wdata = wdata;
    HREADY = 1'b1; HRESP = 1'b0;
    rsp_ready = (rdly == 0);
    for (int c = 1; c < 200 && !done; c++) begin
      @(negedge HCLK);
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_write = ~wr;
      cmd_addr  = $urandom;
      cmd_size  = 2'($urandom_range(0, 3));
      cmd_wdata = $urandom;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
      if (hs) begin
        check("rsp_valid_drop", {31'h0, rsp_valid}, 32'h0);
        check("cmd_ready_back", {31'h0, cmd_ready}, 32'h1);
        done = 1'b1;
      end else begin
        if (cmd_ready) bad++;
        if (HTRANS == 2'b10) begin
          nonseq++;
          if (HADDR !== addr || HSIZE !== {1'b0, size} || HWRITE !== wr) bad++;
          if (ak < aw) begin
            HREADY = 1'b0;
            ak++;
          end else begin
            phase = 2;
          end
        end else if (phase == 2) begin
          if (HTRANS !== 2'b00 || HADDR !== addr) bad++;
          if (wr && HWDATA !== exp_hw) bad++;
          if (dk < dw) HREADY = 1'b0;
          else if (serr && dk == dw) begin
            HREADY = 1'b0; HRESP = 1'b1;
          end else begin
            HRESP  = serr;
            HRDATA = srd;
            phase  = 0;
          end
          dk++;
        end else if (HTRANS !== 2'b00) bad++;
        if (rsp_valid) begin
          if (got_lat < 0) begin
            got_lat = c; got_rdata = rsp_rdata; got_err = rsp_err;
          end else if (rsp_rdata !== got_rdata || rsp_err !== got_err) bad++;
          if (!rsp_ready && (c - got_lat) >= rdly) rsp_ready = 1'b1;
          if (rsp_ready) hs = 1'b1;
        end
      end
    end
    check("cmd_complete", {31'h0, done}, 32'h1);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  task automatic apply(input string tag, input vec_t v);
    run_cmd(v.wr, v.addr, v.size, v.wdata, v.aw, v.dw, v.serr, v.srd, v.rdly,
            g_rdata, g_err, g_lat, g_nonseq, g_bad);
    check({tag, "_rdata"}, g_rdata, v.e_rdata);
    check({tag, "_err"}, {30'h0, g_err}, {30'h0, v.e_err});
    check({tag, "_lat"}, 32'(g_lat), 32'(v.e_lat));
    check({tag, "_nonseq"}, 32'(g_nonseq), 32'(v.e_nonseq));
    check({tag, "_protocol"}, 32'(g_bad), 32'h0);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 32'h4000_0010, 2'd2, 32'h0,         0, 0, 1'b0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 2'd0, 3, 1};
    tbl[1]  = '{1'b1, 32'h4000_0003, 2'd0, 32'h0000_00A5, 0, 2, 1'b0, 32'h0,         0, 32'h0,         2'd0, 5, 1};
    tbl[2]  = '{1'b0, 32'h4000_0002, 2'd1, 32'h0,         0, 0, 1'b0, 32'h1234_5678, 0, 32'h0000_1234, 2'd0, 3, 1};
    tbl[3]  = '{1'b1, 32'h4000_0020, 2'd2, 32'hCAFE_F00D, 0, 0, 1'b1, 32'h0,         0, 32'h0,         2'd1, 4, 1};
    tbl[4]  = '{1'b0, 32'h4000_0001, 2'd2, 32'h0,         0, 0, 1'b0, 32'h0,         0, 32'h0,         2'd2, 1, 0};
    tbl[5]  = '{1'b1, 32'h4000_0000, 2'd3, 32'h1111_1111, 0, 0, 1'b0, 32'h0,         0, 32'h0,         2'd3, 1, 0};
    tbl[6]  = '{1'b0, 32'h4000_0001, 2'd0, 32'h0,         0, 0, 1'b0, 32'h1234_5678, 4, 32'h0000_0056, 2'd0, 3, 1};
    tbl[7]  = '{1'b1, 32'h4000_0003, 2'd1, 32'hBEEF,      0, 0, 1'b0, 32'h0,         0, 32'h0,         2'd2, 1, 0};
    tbl[8]  = '{1'b0, 32'h4000_0004, 2'd2, 32'h0,         2, 1, 1'b0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 2'd0, 6, 3};
    tbl[9]  = '{1'b0, 32'h4000_0000, 2'd1, 32'h0,         0, 3, 1'b1, 32'hFFFF_FFFF, 0, 32'h0,         2'd1, 7, 1};
    tbl[10] = '{1'b0, 32'h4000_0003, 2'd0, 32'h0,         0, 0, 1'b0, 32'hAB00_0000, 1, 32'h0000_00AB, 2'd0, 3, 1};

    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_size = 2'd0;
    cmd_wdata = 32'h0; rsp_ready = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    repeat (2) @(negedge HCLK);
    check("reset_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    check("reset_bus", {HTRANS, HSIZE, HWRITE, 26'h0}, 32'h0);
    check("reset_haddr", HADDR, 32'h0);
    check("reset_hwdata", HWDATA, 32'h0);
    check("reset_rsp", {rsp_valid, rsp_err, 29'h0}, 32'h0);
    check("reset_rdata", rsp_rdata, 32'h0);
    check("const_outputs", {24'h0, HBURST, HPROT, HMASTLOCK}, {24'h0, 3'b000, 4'b0011, 1'b0});
    HRESETn = 1'b1;

    for (int i = 0; i < 11; i++) apply($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 40; i++) begin
      vec_t r;
      r.wr    = $urandom_range(0, 1) == 1;
      r.addr  = $urandom;
      r.size  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) r.addr = r.addr & ~((32'h1 << r.size) - 32'h1);
      r.wdata = $urandom;
      r.aw    = $urandom_range(0, 2);
      r.dw    = $urandom_range(0, 3);
      r.serr  = $urandom_range(0, 4) == 0;
      r.srd   = $urandom;
      r.rdly  = $urandom_range(0, 3);
      model(r.wr, r.addr, r.size, r.aw, r.dw, r.serr, r.srd, m_rdata, m_err, m_lat, m_nonseq);
      r.e_rdata = m_rdata; r.e_err = m_err; r.e_lat = m_lat; r.e_nonseq = m_nonseq;
      apply($sformatf("rnd%0d", i), r);
    end

    // Reset asserted while the slave is stretching the data phase.
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_0008; cmd_size = 2'd2;
    cmd_wdata = 32'h1122_3344; rsp_ready = 1'b1; HREADY = 1'b1;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    check("rst_seq_nonseq", {30'h0, HTRANS}, 32'h2);
    @(negedge HCLK);
    HREADY = 1'b0;
    check("rst_seq_hwdata", HWDATA, 32'h1122_3344);
    #2 HRESETn = 1'b0;
    #1;
    check("rst_mid_bus", {HTRANS, HSIZE, HWRITE, rsp_valid, rsp_err, cmd_ready, 21'h0}, 32'h0);
    check("rst_mid_haddr", HADDR, 32'h0);
    check("rst_mid_hwdata", HWDATA, 32'h0);
    check("rst_mid_rdata", rsp_rdata, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1; HREADY = 1'b1; rsp_ready = 1'b0;
    @(negedge HCLK);
    check("rst_recover_ready", {31'h0, cmd_ready}, 32'h1);
    apply("post_reset", tbl[2]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
